uart_tx_port: RTL
=================

// Module: uart_tx_port
// PURPOSE
//  Memory-mapped UART transmitter on the MIPS data bus, beside the 16-bit bidirectional port.
//  Consumes processor stores: bytes go into a FIFO and are serialised as 8N1 on tx.
//  Same slave interface style as the port: address[1:0], rw, ce, 16-bit data_in/data_out.
//  The top-level decoder drives ce for its address window.
// PARAMETERS
//  DATA_WIDTH   16   bus data width; bits [7:0] carry the byte
//  FIFO_DEPTH   8    TX FIFO entries, power of 2, >= 2
//  DEFAULT_DIV  217  reset value of the baud divisor (25 MHz / 115200)
//  DIV_WIDTH    16   baud divisor register width
// PORTS
//  clk       in   1           system clock (sys_clk, 25 MHz)
//  rst_n     in   1           asynchronous, active-low reset
//  data_in   in   DATA_WIDTH  write data from processor
//  data_out  out  DATA_WIDTH  read data to processor
//  address   in   2           register select: 00 DATA, 01 STATUS, 10 BAUD, 11 reserved
//  rw        in   1           1 = write (store), 0 = read (load)
//  ce        in   1           chip enable, one cycle per access
//  tx        out  1           serial output, idles high
//  irq       out  1           level: FIFO empty and transmitter idle
// BEHAVIOUR
//  Reset: tx=1, irq=1, data_out=0, FIFO empty, overflow=0, baud=DEFAULT_DIV, FSM=IDLE.
//  Reset mid-frame aborts the frame; tx returns high asynchronously.
//  Reads are combinational (single-cycle MIPS): data_out valid in the same cycle when ce & ~rw, else 0.
//   DATA reads 0.
//   STATUS = {8'b0, overflow, busy, full, empty, count[3:0]}; count saturates at 15.
//   BAUD reads the divisor.
//  Writes are registered on the rising clk edge when ce & rw:
//   DATA: push data_in[7:0] if not full. If full, drop the byte and set overflow (sticky).
//   STATUS: any write clears overflow.
//   BAUD: loads the divisor. Value 0 is treated as 1.
//  Simultaneous push and pop:
//   FIFO not full: both happen and count is unchanged.
//   FIFO full: pop happens, push is dropped and sets overflow.
//  FSM IDLE -> START -> DATA -> STOP -> (IDLE | START):
//   IDLE: tx=1. If the FIFO is not empty: pop the head into the shift register, latch the
//    divisor into active_div, go to START.
//   START: tx=0 for active_div cycles.
//   DATA: 8 bits, LSB first, each held active_div cycles; 3-bit bit counter.
//   STOP: tx=1 for active_div cycles. At the end, if the FIFO is not empty: pop the next byte,
//    relatch the divisor, go straight to START (no idle gap). Otherwise go to IDLE.
//  Baud counter: loads active_div-1 on state or bit entry, counts down, advances at 0.
//   Frame = 10*active_div cycles.
//  Divisor writes during a frame take effect only at the next frame start.
//  Latency: with the FIFO empty and IDLE, the DATA write edge and the tx falling edge are
//   2 clk edges apart (push, then pop/START).
//  busy = (state != IDLE). irq = empty & ~busy.
// STRUCTURE
//  Include file uart_defs.vh: register address localparams (DATA/STATUS/BAUD), FSM state
//   encodings, STATUS bit positions. Shared with software headers and the bench.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/count, async active-low reset,
//   wrapping pointers plus one extra bit for full/empty.
//  Top: register decode, overflow flag, baud counter, FSM, shift register.
// TESTING (bench uses DEFAULT_DIV=4)
//  Single byte: write DATA=0x0055.
//   -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4.
//   -> 40-cycle frame; irq goes low, then returns high after the stop bit.
//  Back-to-back: write 0xA1 then 0x3C.
//   -> second START begins on the cycle after the first STOP ends; 80 cycles total.
//  Overflow: while the 1st byte is in flight, write bytes until the 8 FIFO entries are full,
//   then write 0xFF.
//   -> STATUS reads full=1, overflow=1, count=8; 0xFF is never transmitted.
//   -> a STATUS write clears overflow.
//  Divisor change: write BAUD=8 mid-frame.
//   -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits (80 cycles).
//   -> BAUD=0 gives 1-cycle bits.
//  Reset mid-frame: assert rst_n=0 during DATA bit 3.
//   -> tx=1 immediately; STATUS=0x0010 after release; nothing further transmitted.
//  Read path: ce=1, rw=0, address=01 with the FIFO empty -> data_out=0x0010 in the same cycle;
//   ce=0 -> data_out=0.

Source files
------------

// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, FSM state encoding and small helpers.
package uart_tx_port_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_BAUD   = 2'b10;

  localparam int STAT_OVF_BIT   = 7;
  localparam int STAT_BUSY_BIT  = 6;
  localparam int STAT_FULL_BIT  = 5;
  localparam int STAT_EMPTY_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // STATUS only has a 4-bit count field; deeper FIFOs report 15.
  function automatic logic [3:0] sat_count4(input int unsigned cnt);
    return (cnt > 32'd15) ? 4'd15 : cnt[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_port_fifo.sv
// Synchronous FIFO with wrapping pointers carrying one extra lap bit,
// so full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: bus register decode, sticky overflow,
// baud divisor, TX FIFO and the serialising FSM.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(217)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [1:0]            address,
  input  logic                  rw,
  input  logic                  ce,
  output logic                  tx,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_s, push_s, pop_s, full_s, empty_s, busy_s;
  logic [7:0]           fifo_rdata_s;
  logic [CW-1:0]        count_s;
  logic [DIV_WIDTH-1:0] div_eff_s;
  logic [15:0]          status_s;

  logic                 ovf_q;
  logic [DIV_WIDTH-1:0] div_q, active_div_q, baud_cnt_q;
  tx_state_e            state_q;
  logic [7:0]           shift_q;
  logic [2:0]           bit_cnt_q;
  logic                 tx_q;

  assign wr_s      = ce & rw;
  assign push_s    = wr_s & (address == ADDR_DATA);
  assign div_eff_s = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  // Pop exactly when the FSM starts a frame: from IDLE, or at the last stop-bit cycle.
  assign pop_s     = ~empty_s & ((state_q == ST_IDLE) ||
                                 ((state_q == ST_STOP) && (baud_cnt_q == '0)));
  assign busy_s    = (state_q != ST_IDLE);
  assign irq       = empty_s & ~busy_s;
  assign tx        = tx_q;
  assign status_s  = {8'h00, ovf_q, busy_s, full_s, empty_s, sat_count4(32'(count_s))};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (data_in[7:0]),
    .rdata_o (fifo_rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  always_comb begin
    data_out = '0;
    if (ce && !rw) begin
      case (address)
        ADDR_STATUS: data_out = DATA_WIDTH'(status_s);
        ADDR_BAUD:   data_out = DATA_WIDTH'(div_q);
        default:     data_out = '0;
      endcase
    end else begin
      data_out = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      div_q <= DEFAULT_DIV;
    end else begin
      if (push_s && full_s) begin
        ovf_q <= 1'b1;
      end else if (wr_s && (address == ADDR_STATUS)) begin
        ovf_q <= 1'b0;
      end
      if (wr_s && (address == ADDR_BAUD)) div_q <= data_in[DIV_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tx_q         <= 1'b1;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      baud_cnt_q   <= '0;
      active_div_q <= DIV_WIDTH'(1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!empty_s) begin
            shift_q      <= fifo_rdata_s;
            active_div_q <= div_eff_s;
            baud_cnt_q   <= div_eff_s - DIV_WIDTH'(1);
            tx_q         <= 1'b0;
            state_q      <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt_q == '0) begin
            tx_q       <= shift_q[0];
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= active_div_q - DIV_WIDTH'(1);
            state_q    <= ST_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_WIDTH'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt_q == '0) begin
            baud_cnt_q <= active_div_q - DIV_WIDTH'(1);
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_WIDTH'(1);
          end
        end
        ST_STOP: begin
          if (baud_cnt_q == '0) begin
            if (!empty_s) begin
              shift_q      <= fifo_rdata_s;
              active_div_q <= div_eff_s;
              baud_cnt_q   <= div_eff_s - DIV_WIDTH'(1);
              tx_q         <= 1'b0;
              state_q      <= ST_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_WIDTH'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
